// File: rtl/arb8_pkg.sv
// Shared constants, state encoding and helpers for the 8-way one-hot arbiter.
package arb8_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    localparam logic PRIO_RR    = 1'b0;
    localparam logic PRIO_FIXED = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index of the set bit of a one-hot vector (0 for an all-zero vector).
    function automatic logic [IDX_W-1:0] oh_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter8_onehot_if.sv
// Request/grant bundle between requesters, the arbiter and the downstream encoder.
//   req         : request pulses/levels, bit i = requester i
//   flush       : synchronous clear of pending requests and current grant
//   grant_ready : downstream accepts the current grant
//   grant_valid : a grant is presented (encoder enable)
//   grant_oh    : one-hot grant (encoder inputs Y7..Y0)
//   pending     : registered pending-request status
interface rr_arbiter8_onehot_if;
    import arb8_pkg::*;

    logic [N_REQ-1:0] req;
    logic             flush;
    logic             grant_ready;
    logic             grant_valid;
    logic [N_REQ-1:0] grant_oh;
    logic [N_REQ-1:0] pending;

    // Requester / downstream side
    modport master (
        output req,
        output flush,
        output grant_ready,
        input  grant_valid,
        input  grant_oh,
        input  pending
    );

    // Arbiter side
    modport slave (
        input  req,
        input  flush,
        input  grant_ready,
        output grant_valid,
        output grant_oh,
        output pending
    );

endinterface

// File: rtl/rr_pick8.sv
// Combinational picker: selects one pending requester as a one-hot vector.
//   pending : candidate requests
//   ptr     : round-robin start index (highest priority position)
//   mode    : PRIO_RR = rotate/lowest-pick/rotate-back, PRIO_FIXED = highest index
//   sel_oh  : one-hot selection, zero when nothing is pending
//   any     : at least one candidate pending
module rr_pick8
    import arb8_pkg::*;
(
    input  logic [N_REQ-1:0] pending,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic [N_REQ-1:0] sel_oh,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] pick_rot;
    logic [N_REQ-1:0] sel_rr;
    logic [N_REQ-1:0] sel_hi;

    // Rotate so that position ptr lands on bit 0; index arithmetic wraps mod 8.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = pending[IDX_W'(i) + ptr];
        end
    end

    // Lowest set bit of the rotated vector is the first requester at or after ptr.
    assign pick_rot = rot & (~rot + N_REQ'(1));

    // Rotate the pick back into requester numbering.
    always_comb begin
        sel_rr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_rr[IDX_W'(i) + ptr] = pick_rot[i];
        end
    end

    // Fixed priority: ascending scan, so the highest set index is the last write.
    always_comb begin
        sel_hi = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pending[i]) begin
                sel_hi = N_REQ'(1) << i;
            end
        end
    end

    assign sel_oh = (mode == PRIO_FIXED) ? sel_hi : sel_rr;
    assign any    = |pending;

endmodule

// File: rtl/rr_arbiter8_onehot.sv
// 8-way request latch and arbiter driving a registered one-hot grant to an 8:3 encoder.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of rr_arbiter8_onehot_if (req/flush/grant_ready in,
//                grant_valid/grant_oh/pending out, all outputs registered)
//   PRIO_MODE  : 0 = round-robin, 1 = fixed priority (highest index wins)
module rr_arbiter8_onehot
    import arb8_pkg::*;
#(
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    rr_arbiter8_onehot_if.slave bus
);

    localparam logic MODE = (PRIO_MODE == 1) ? PRIO_FIXED : PRIO_RR;

    arb_state_e       state_q,       state_d;
    logic [IDX_W-1:0] ptr_q,         ptr_d;
    logic [N_REQ-1:0] pending_q,     pending_d;
    logic [N_REQ-1:0] grant_oh_q,    grant_oh_d;
    logic             grant_valid_q, grant_valid_d;

    logic             accept;
    logic [N_REQ-1:0] accept_mask;
    logic [N_REQ-1:0] remaining;
    logic [IDX_W-1:0] pick_ptr;
    logic [N_REQ-1:0] pick_pend;
    logic [N_REQ-1:0] sel_oh;
    logic             sel_any;

    assign accept      = grant_valid_q & bus.grant_ready;
    assign accept_mask = accept ? grant_oh_q : '0;
    assign remaining   = pending_q & ~accept_mask;

    // On accept the follow-on grant is chosen from what remains, using the advanced ptr.
    always_comb begin
        pick_ptr = ptr_q;
        if (accept && (MODE == PRIO_RR)) begin
            pick_ptr = oh_to_idx(grant_oh_q) + IDX_W'(1);
        end
    end

    assign pick_pend = remaining;

    rr_pick8 u_pick (
        .pending (pick_pend),
        .ptr     (pick_ptr),
        .mode    (MODE),
        .sel_oh  (sel_oh),
        .any     (sel_any)
    );

    // Pending latch: a new req wins over the accept of the same line; flush drops everything.
    always_comb begin
        pending_d = remaining | bus.req;
        if (bus.flush) begin
            pending_d = '0;
        end
    end

    // Next-state and grant register logic.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_oh_d    = grant_oh_q;
        grant_valid_d = grant_valid_q;

        if (bus.flush) begin
            state_d       = IDLE;
            grant_oh_d    = '0;
            grant_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    grant_oh_d    = '0;
                    grant_valid_d = 1'b0;
                    if (sel_any) begin
                        grant_oh_d    = sel_oh;
                        grant_valid_d = 1'b1;
                        state_d       = GRANT;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        ptr_d = pick_ptr;
                        if (sel_any) begin
                            grant_oh_d    = sel_oh;
                            grant_valid_d = 1'b1;
                        end else begin
                            grant_oh_d    = '0;
                            grant_valid_d = 1'b0;
                            state_d       = IDLE;
                        end
                    end
                end
                default: begin
                    state_d       = IDLE;
                    grant_oh_d    = '0;
                    grant_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State, pointer, pending and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            pending_q     <= '0;
            grant_oh_q    <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            pending_q     <= pending_d;
            grant_oh_q    <= grant_oh_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_oh    = grant_oh_q;
    assign bus.pending     = pending_q;

endmodule

// File: tb/tb_rr_arbiter8_onehot.sv
// Directed bench for rr_arbiter8_onehot: a round-robin and a fixed-priority instance
// driven with identical stimulus.
module tb_rr_arbiter8_onehot;
    import arb8_pkg::*;

    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    rr_arbiter8_onehot_if if_rr ();
    rr_arbiter8_onehot_if if_fx ();

    rr_arbiter8_onehot #(.PRIO_MODE(0)) dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_rr)
    );

    rr_arbiter8_onehot #(.PRIO_MODE(1)) dut_fx (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_fx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [7:0] r, input logic f, input logic rdy);
        if_rr.req = r;  if_rr.flush = f;  if_rr.grant_ready = rdy;
        if_fx.req = r;  if_fx.flush = f;  if_fx.grant_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Grant invariants on every cycle for both instances.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rr_onehot0", 8'($onehot0(if_rr.grant_oh)), 8'd1);
            chk("rr_valid_eq_or", 8'(if_rr.grant_valid), 8'(|if_rr.grant_oh));
            chk("fx_onehot0", 8'($onehot0(if_fx.grant_oh)), 8'd1);
            chk("fx_valid_eq_or", 8'(if_fx.grant_valid), 8'(|if_fx.grant_oh));
        end
    end

    initial begin
        rst_n = 1'b0;
        set_in(8'h00, 1'b0, 1'b0);
        #12;
        rst_n = 1'b1;

        // Reset state
        chk("rst_valid", 8'(if_rr.grant_valid), 8'h00);
        chk("rst_oh", if_rr.grant_oh, 8'h00);
        chk("rst_pending", if_rr.pending, 8'h00);
        chk("rst_ptr", 8'(dut_rr.ptr_q), 8'h00);

        // 1: single request, two-cycle latency, ptr advances past it
        set_in(8'h08, 1'b0, 1'b1);
        tick();
        chk("t1_pend", if_rr.pending, 8'h08);
        chk("t1_valid_early", 8'(if_rr.grant_valid), 8'h00);
        set_in(8'h00, 1'b0, 1'b1);
        tick();
        chk("t1_valid", 8'(if_rr.grant_valid), 8'h01);
        chk("t1_oh", if_rr.grant_oh, 8'h08);
        tick();
        chk("t1_pend_clr", if_rr.pending, 8'h00);
        chk("t1_valid_off", 8'(if_rr.grant_valid), 8'h00);
        chk("t1_ptr", 8'(dut_rr.ptr_q), 8'h04);

        // 2: all requesters held, back-to-back rotation from ptr=0
        do_reset();
        set_in(8'hFF, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("t2_oh%0d", i), if_rr.grant_oh, 8'(8'h01 << i));
            chk($sformatf("t2_valid%0d", i), 8'(if_rr.grant_valid), 8'h01);
        end
        tick();
        chk("t2_wrap", if_rr.grant_oh, 8'h01);

        // 3: backpressure holds the grant; higher line does not preempt
        do_reset();
        set_in(8'h02, 1'b0, 1'b0);
        tick();
        set_in(8'h00, 1'b0, 1'b0);
        tick();
        chk("t3_first", if_rr.grant_oh, 8'h02);
        set_in(8'h80, 1'b0, 1'b0);
        tick();
        chk("t3_hold0", if_rr.grant_oh, 8'h02);
        set_in(8'h00, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk($sformatf("t3_hold%0d", i), if_rr.grant_oh, 8'h02);
        end
        chk("t3_pend", if_rr.pending, 8'h82);
        set_in(8'h00, 1'b0, 1'b1);
        tick();
        chk("t3_next", if_rr.grant_oh, 8'h80);
        chk("t3_next_valid", 8'(if_rr.grant_valid), 8'h01);
        tick();
        chk("t3_idle", 8'(if_rr.grant_valid), 8'h00);

        // 4: wrap from ptr=7, and fixed priority on the same pending set
        do_reset();
        set_in(8'h40, 1'b0, 1'b1);
        tick();
        set_in(8'h00, 1'b0, 1'b1);
        tick();
        chk("t4_rr_g6", if_rr.grant_oh, 8'h40);
        chk("t4_fx_g6", if_fx.grant_oh, 8'h40);
        tick();
        chk("t4_ptr7", 8'(dut_rr.ptr_q), 8'h07);
        set_in(8'h09, 1'b0, 1'b1);
        tick();
        chk("t4_pend", if_rr.pending, 8'h09);
        set_in(8'h00, 1'b0, 1'b1);
        tick();
        chk("t4_rr_a", if_rr.grant_oh, 8'h01);
        chk("t4_fx_a", if_fx.grant_oh, 8'h08);
        tick();
        chk("t4_rr_b", if_rr.grant_oh, 8'h08);
        chk("t4_fx_b", if_fx.grant_oh, 8'h01);
        tick();
        chk("t4_rr_idle", 8'(if_rr.grant_valid), 8'h00);
        chk("t4_fx_idle", 8'(if_fx.grant_valid), 8'h00);

        // 5: flush during a grant beats accept and drops same-cycle req
        do_reset();
        set_in(8'h08, 1'b0, 1'b1);
        tick();
        set_in(8'h00, 1'b0, 1'b1);
        tick();
        tick();
        set_in(8'h31, 1'b0, 1'b0);
        tick();
        set_in(8'h00, 1'b0, 1'b0);
        tick();
        chk("t5_oh", if_rr.grant_oh, 8'h10);
        chk("t5_pend", if_rr.pending, 8'h31);
        set_in(8'h01, 1'b1, 1'b1);
        tick();
        chk("t5_valid", 8'(if_rr.grant_valid), 8'h00);
        chk("t5_oh_clr", if_rr.grant_oh, 8'h00);
        chk("t5_pend_clr", if_rr.pending, 8'h00);
        chk("t5_ptr", 8'(dut_rr.ptr_q), 8'h04);
        set_in(8'h00, 1'b0, 1'b0);
        tick();
        chk("t5_drop_pend", if_rr.pending, 8'h00);
        tick();
        chk("t5_drop_valid", 8'(if_rr.grant_valid), 8'h00);

        // 6: asynchronous reset while a grant is held
        do_reset();
        set_in(8'h04, 1'b0, 1'b0);
        tick();
        set_in(8'h00, 1'b0, 1'b0);
        tick();
        chk("t6_pre", if_rr.grant_oh, 8'h04);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 8'(if_rr.grant_valid), 8'h00);
        chk("t6_oh", if_rr.grant_oh, 8'h00);
        chk("t6_pend", if_rr.pending, 8'h00);
        #2;
        rst_n = 1'b1;
        tick();
        chk("t6_lost", 8'(if_rr.grant_valid), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
